// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit signal bundle: control from the core, IROM read port and the decode-side outputs.
// master = the fetch unit, slave = whatever surrounds it (core control, IROM, decoder).
interface instr_fetch_unit_if #(
    parameter int IROM_AW = 10
);
    logic               setup;
    logic [31:0]        boot_addr;
    logic               stall;
    logic               redirect_valid;
    logic [31:0]        redirect_addr;
    logic [IROM_AW-1:0] imem_addr;
    logic               imem_rd_en;
    logic [31:0]        imem_rdata;
    logic [31:0]        instr_out;
    logic [31:0]        pc_out;
    logic [31:0]        pc_plus4_out;
    logic               instr_valid;

    modport master (
        input  setup, boot_addr, stall, redirect_valid, redirect_addr, imem_rdata,
        output imem_addr, imem_rd_en, instr_out, pc_out, pc_plus4_out, instr_valid
    );

    modport slave (
        output setup, boot_addr, stall, redirect_valid, redirect_addr, imem_rdata,
        input  imem_addr, imem_rd_en, instr_out, pc_out, pc_plus4_out, instr_valid
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// PESURV fetch stage: PC ownership, IROM reads, stall skid hold and redirect bubble.
// Optional perf counters (perf_fetched / perf_bubbles) are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IROM_AW  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_bubbles
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        SETUP = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fpc, fpc_nxt;
    logic [31:0] dpc, dpc_nxt;
    logic        d_valid, d_valid_nxt;
    logic        hold_valid, hold_valid_nxt;
    logic        hold_load;
    logic [31:0] hold_instr;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Next-state and IROM read enable; setup outranks redirect, which outranks stall.
    always_comb begin
        state_nxt      = state;
        fpc_nxt        = fpc;
        dpc_nxt        = dpc;
        d_valid_nxt    = d_valid;
        hold_valid_nxt = hold_valid;
        hold_load      = 1'b0;
        bus.imem_rd_en = 1'b0;
        case (state)
            SETUP: begin
                if (bus.setup) begin
                    fpc_nxt = word_align(bus.boot_addr);
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.imem_rd_en = ~bus.stall | bus.redirect_valid;
                if (bus.setup) begin
                    state_nxt      = SETUP;
                    d_valid_nxt    = 1'b0;
                    hold_valid_nxt = 1'b0;
                    fpc_nxt        = word_align(bus.boot_addr);
                end else if (bus.redirect_valid) begin
                    fpc_nxt        = word_align(bus.redirect_addr);
                    d_valid_nxt    = 1'b0;
                    hold_valid_nxt = 1'b0;
                end else if (bus.stall) begin
                    // IROM output is only trustworthy on the first stalled cycle; capture it then.
                    if (d_valid && !hold_valid) begin
                        hold_load      = 1'b1;
                        hold_valid_nxt = 1'b1;
                    end
                end else begin
                    dpc_nxt        = fpc;
                    d_valid_nxt    = 1'b1;
                    fpc_nxt        = fpc + 32'd4;
                    hold_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = SETUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SETUP;
            fpc        <= RESET_PC;
            dpc        <= 32'h0000_0000;
            d_valid    <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            fpc        <= fpc_nxt;
            dpc        <= dpc_nxt;
            d_valid    <= d_valid_nxt;
            hold_valid <= hold_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (hold_load) begin
            hold_instr <= bus.imem_rdata;
        end
    end

    // Decode-side view
    assign bus.imem_addr    = fpc[IROM_AW+1:2];
    assign bus.instr_out    = hold_valid ? hold_instr : (d_valid ? bus.imem_rdata : NOP);
    assign bus.instr_valid  = d_valid & (state == RUN);
    assign bus.pc_out       = dpc;
    assign bus.pc_plus4_out = dpc + 32'd4;

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    // Counters are cleared for the whole SETUP period, including the edge that enters it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'h0000_0000;
            perf_bubbles <= 32'h0000_0000;
        end else if (state != RUN || bus.setup) begin
            perf_fetched <= 32'h0000_0000;
            perf_bubbles <= 32'h0000_0000;
        end else begin
            if (bus.instr_valid && !bus.stall) begin
                perf_fetched <= sat_inc(perf_fetched);
            end
            if (!bus.instr_valid) begin
                perf_bubbles <= sat_inc(perf_bubbles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized control checked against
// a decode-level reference model (what instruction/PC decode should see each cycle).
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] IA  = 32'hA1A1_0001;
    localparam logic [31:0] IB  = 32'hB2B2_0002;
    localparam logic [31:0] IC  = 32'hC3C3_0003;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    instr_fetch_unit_if #(.IROM_AW(10)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .IROM_AW(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // IROM: one-cycle read latency, garbage on the output when not read.
    logic [31:0] irom [1024];
    always @(posedge clk) begin
        if (bus.imem_rd_en) bus.imem_rdata <= irom[bus.imem_addr];
        else                bus.imem_rdata <= $urandom;
    end

    // Reference model: mode, next PC to fetch, and what decode currently sees.
    bit          m_run;
    logic [31:0] m_next_pc;
    logic [31:0] m_pc;
    bit          m_valid;
    logic [96:0] got;
    logic [96:0] exp;

    task automatic model_reset();
        m_run     = 1'b0;
        m_next_pc = 32'h0000_0000;
        m_pc      = 32'h0000_0000;
        m_valid   = 1'b0;
    endtask

    function automatic logic [96:0] model_view();
        logic        v;
        logic [31:0] ins;
        v   = m_valid && m_run;
        ins = v ? irom[m_pc[11:2]] : NOP;
        return {v, ins, m_pc, m_pc + 32'd4};
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (!m_run) begin
            if (bus.setup) m_next_pc = bus.boot_addr & ~32'h3;
            else           m_run = 1'b1;
        end else if (bus.setup) begin
            m_run     = 1'b0;
            m_valid   = 1'b0;
            m_next_pc = bus.boot_addr & ~32'h3;
        end else if (bus.redirect_valid) begin
            m_valid   = 1'b0;
            m_next_pc = bus.redirect_addr & ~32'h3;
        end else if (!bus.stall) begin
            m_valid   = 1'b1;
            m_pc      = m_next_pc;
            m_next_pc = m_next_pc + 32'd4;
        end
        #1;
        got = {bus.instr_valid, bus.instr_out, bus.pc_out, bus.pc_plus4_out};
    endtask

    task automatic boot(input logic [31:0] addr);
        bus.setup          = 1'b1;
        bus.boot_addr      = addr;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        step();
        bus.setup = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        bus.setup          = 1'b1;
        bus.boot_addr      = 32'h0000_0100;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 32'h0;
        model_reset();
        step();
        step();
        checks++;
        if (got !== {1'b0, NOP, 32'h0, 32'h4}) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", got, {1'b0, NOP, 32'h0, 32'h4});
        end
        checks++;
        if (bus.imem_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_rd_en got=%b exp=0", bus.imem_rd_en);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        boot(32'h0000_0100);
        checks++;
        if (got[96] !== 1'b0) begin
            failures++;
            $display("FAIL basic_first_bubble valid got=%b exp=0", got[96]);
        end
        step();
        checks++;
        if (got !== {1'b1, IA, 32'h100, 32'h104}) begin
            failures++;
            $display("FAIL basic_A got=%h exp=%h", got, {1'b1, IA, 32'h100, 32'h104});
        end
        step();
        checks++;
        if (got !== {1'b1, IB, 32'h104, 32'h108}) begin
            failures++;
            $display("FAIL basic_B got=%h exp=%h", got, {1'b1, IB, 32'h104, 32'h108});
        end
        step();
        checks++;
        if (got !== {1'b1, IC, 32'h108, 32'h10C}) begin
            failures++;
            $display("FAIL basic_C got=%h exp=%h", got, {1'b1, IC, 32'h108, 32'h10C});
        end
    endtask

    task automatic test_stall();
        boot(32'h0000_0100);
        step();
        step();
        bus.stall = 1'b1;
        #1;
        checks++;
        if (bus.imem_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL stall_rd_en got=%b exp=0", bus.imem_rd_en);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (got !== {1'b1, IB, 32'h104, 32'h108}) begin
                failures++;
                $display("FAIL stall_hold_%0d got=%h exp=%h", i, got, {1'b1, IB, 32'h104, 32'h108});
            end
        end
        bus.stall = 1'b0;
        step();
        checks++;
        if (got !== {1'b1, IC, 32'h108, 32'h10C}) begin
            failures++;
            $display("FAIL stall_release_C got=%h exp=%h", got, {1'b1, IC, 32'h108, 32'h10C});
        end
        step();
        checks++;
        if (got !== {1'b1, irom[10'h043], 32'h10C, 32'h110}) begin
            failures++;
            $display("FAIL stall_release_next got=%h exp=%h", got, {1'b1, irom[10'h043], 32'h10C, 32'h110});
        end
    endtask

    task automatic test_redirect();
        boot(32'h0000_0100);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h0000_0203;
        step();
        checks++;
        if (got[96:64] !== {1'b0, NOP}) begin
            failures++;
            $display("FAIL redirect_bubble got=%h exp=%h", got[96:64], {1'b0, NOP});
        end
        bus.redirect_valid = 1'b0;
        step();
        checks++;
        if (got !== {1'b1, irom[10'h080], 32'h200, 32'h204}) begin
            failures++;
            $display("FAIL redirect_target got=%h exp=%h", got, {1'b1, irom[10'h080], 32'h200, 32'h204});
        end
    endtask

    task automatic test_redirect_stall();
        boot(32'h0000_0100);
        step();
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h0000_0204;
        #1;
        checks++;
        if (bus.imem_rd_en !== 1'b1) begin
            failures++;
            $display("FAIL redir_stall_rd_en got=%b exp=1", bus.imem_rd_en);
        end
        step();
        checks++;
        if (got[96:64] !== {1'b0, NOP}) begin
            failures++;
            $display("FAIL redir_stall_bubble got=%h exp=%h", got[96:64], {1'b0, NOP});
        end
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        step();
        checks++;
        if (got !== {1'b1, irom[10'h081], 32'h204, 32'h208}) begin
            failures++;
            $display("FAIL redir_stall_target got=%h exp=%h", got, {1'b1, irom[10'h081], 32'h204, 32'h208});
        end
    endtask

    task automatic test_wrap();
        boot(32'hFFFF_FFF8);
        step();
        checks++;
        if (got !== {1'b1, irom[10'h3FE], 32'hFFFF_FFF8, 32'hFFFF_FFFC}) begin
            failures++;
            $display("FAIL wrap_fff8 got=%h exp=%h", got, {1'b1, irom[10'h3FE], 32'hFFFF_FFF8, 32'hFFFF_FFFC});
        end
        step();
        checks++;
        if (got !== {1'b1, irom[10'h3FF], 32'hFFFF_FFFC, 32'h0}) begin
            failures++;
            $display("FAIL wrap_fffc got=%h exp=%h", got, {1'b1, irom[10'h3FF], 32'hFFFF_FFFC, 32'h0});
        end
        step();
        checks++;
        if (got !== {1'b1, irom[10'h000], 32'h0, 32'h4}) begin
            failures++;
            $display("FAIL wrap_zero got=%h exp=%h", got, {1'b1, irom[10'h000], 32'h0, 32'h4});
        end
    endtask

    task automatic test_async_reset();
        boot(32'h0000_0100);
        step();
        step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        got = {bus.instr_valid, bus.instr_out, bus.pc_out, bus.pc_plus4_out};
        checks++;
        if (got !== {1'b0, NOP, 32'h0, 32'h4} || bus.imem_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_now got=%h rd_en=%b exp=%h rd_en=0", got, bus.imem_rd_en, {1'b0, NOP, 32'h0, 32'h4});
        end
        #1;
        rst_n     = 1'b1;
        bus.setup = 1'b0;
        step();
        checks++;
        if (got[96] !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_bubble valid got=%b exp=0", got[96]);
        end
        step();
        checks++;
        if (got !== {1'b1, irom[10'h000], 32'h0, 32'h4}) begin
            failures++;
            $display("FAIL async_reset_resume got=%h exp=%h", got, {1'b1, irom[10'h000], 32'h0, 32'h4});
        end
    endtask

    task automatic test_random();
        logic exp_rd;
        boot($urandom);
        for (int i = 0; i < 600; i++) begin
            bus.setup          = ($urandom_range(0, 99) < 3);
            bus.boot_addr      = $urandom;
            bus.stall          = ($urandom_range(0, 99) < 30);
            bus.redirect_valid = ($urandom_range(0, 99) < 10);
            bus.redirect_addr  = $urandom;
            #1;
            exp_rd = m_run && (!bus.stall || bus.redirect_valid);
            checks++;
            if (bus.imem_rd_en !== exp_rd || bus.imem_addr !== m_next_pc[11:2]) begin
                failures++;
                $display("FAIL rand_irom_%0d rd_en=%b addr=%h exp rd_en=%b addr=%h",
                         i, bus.imem_rd_en, bus.imem_addr, exp_rd, m_next_pc[11:2]);
            end
            step();
            exp = model_view();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL rand_view_%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 1024; i++) irom[i] = $urandom;
        irom[10'h040] = IA;
        irom[10'h041] = IB;
        irom[10'h042] = IC;
        bus.imem_rdata = 32'h0;
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
